button_pulse_gen: RTL and testbench
===================================

# button_pulse_gen

Upstream input-conditioning stage for the mod-16 up/down counters. It takes a raw, bouncing, asynchronous pushbutton and produces a clean single-cycle `pulse` in the `clock` domain. That pulse serves as the counters' count-enable or increment event. It also provides optional hold-to-auto-repeat, so a held button steps the counter at a fixed rate.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive stable synced cycles required to accept a press or a release (≥2)
- `HOLD_CYCLES`, 64, cycles in PRESSED before auto-repeat starts (≥2)
- `REPEAT_CYCLES`, 32, auto-repeat period in cycles (≥2)
- `CNT_W`, 16, timer width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)−1

Ports:
- `clock`  in  1  single clock; all state updates on posedge
- `clear`  in  1  reset, asynchronous, active-high; clears all flops including the synchronizer
- `button_in`  in  1  raw asynchronous button, active-high
- `repeat_en`  in  1  synchronous; enables auto-repeat
- `pulse`  out  1  registered; one-cycle press event; reset 0
- `button_level`  out  1  debounced level; reset 0
- `held`  out  1  high while auto-repeating; reset 0

## Operation
- `button_in` passes through a 2-flop synchronizer; its output is `btn_s`. Both flops reset to 0.
- A single timer `cnt` (CNT_W bits) resets to 0 on every state transition and increments otherwise. It never wraps for legal parameters.
- FSM states:
  - RELEASED
  - PRESS_DEB
  - PRESSED
  - HOLDING
  - RELEASE_DEB
- The reset state is RELEASED.
- RELEASED: when `btn_s`=1, go to PRESS_DEB.
- PRESS_DEB:
  - When `btn_s`=0, go to RELEASED (bounce rejected, no pulse).
  - When `cnt`==DEBOUNCE_CYCLES−1 and `btn_s`=1, go to PRESSED and set `pulse`.
- PRESSED:
  - When `btn_s`=0, go to RELEASE_DEB.
  - Otherwise, when `repeat_en`=1 and `cnt`==HOLD_CYCLES−1, go to HOLDING and set `pulse`.
  - When `repeat_en`=0, `cnt` holds at 0.
- HOLDING:
  - When `btn_s`=0, go to RELEASE_DEB.
  - Otherwise, when `repeat_en`=0, go to PRESSED with no pulse.
  - Otherwise, when `cnt`==REPEAT_CYCLES−1, set `pulse` and restart `cnt`.
- RELEASE_DEB:
  - When `btn_s`=1, go to PRESSED (glitch rejected, no pulse, hold timer restarts).
  - When `cnt`==DEBOUNCE_CYCLES−1 and `btn_s`=0, go to RELEASED.
- Outputs:
  - `pulse` is a register. It is 1 only in the cycle following a pulse-setting edge, and 0 otherwise.
  - `button_level`=1 in PRESSED, HOLDING and RELEASE_DEB.
  - `held`=1 in HOLDING only.
  - Both `button_level` and `held` are decoded from the state register, with no combinational path from inputs.
- Priority within a state: a release condition (`btn_s`=0) beats `repeat_en` and timer expiry.

## Timing
- Press latency: the first posedge sampling `button_in`=1 is edge 1. With `button_in` stable, `pulse` is high during the cycle after edge DEBOUNCE_CYCLES+3.
  - The synchronizer accounts for 2 edges.
  - The RELEASED→PRESS_DEB transition accounts for 1 edge.
  - Debounce accounts for DEBOUNCE_CYCLES edges.
- First repeat pulse follows the press pulse by HOLD_CYCLES edges. Subsequent repeat pulses occur every REPEAT_CYCLES edges.
- Release: `button_level` falls DEBOUNCE_CYCLES+3 edges after the first edge sampling 0.
- `clear` mid-operation:
  - All outputs go to 0 asynchronously.
  - An in-flight pulse is lost.
  - After `clear` deasserts, a still-held button is treated as a fresh press and pulses once with full press latency.
- Consecutive pulses are never closer than 2 cycles.

## Structure
- The shared package holds:
  - the `btn_state_t` enum (5 states)
  - default parameter constants
  - a `cnt_width` helper function
- Natural sub-module: `sync_2ff` (1-bit synchronizer with async clear). It is reusable by other input-conditioning stages.
- The FSM and timer stay in `button_pulse_gen`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Clean press: `repeat_en`=0, `button_in`=1 sampled from edge 1 for 20 cycles, then 0. Exactly one `pulse`, after edge 7. `button_level` is 1 from edge 7 and falls 7 edges after the first 0 sample. `held` stays 0.
- Bounce: `button_in` toggles 1,0,1,0,1,0 on consecutive edges, then holds 1 starting at edge S. Exactly one `pulse`, after edge S+6, since S counts as edge 1.
- Auto-repeat: `repeat_en`=1, `button_in`=1 sampled on edges 1..30. Pulses after edges 7, 15, 19, 23, 27, 31 and no others. `held` is 1 from edge 15 until RELEASE_DEB.
- Release glitch: in PRESSED, `button_in` drops to 0 for 1 cycle. No extra pulse, `button_level` stays 1, and the hold timer restarts.
- `repeat_en` drop: deassert `repeat_en` in HOLDING. Pulses stop, `held`=0 next cycle, and the state is PRESSED.
- Reset mid-operation: assert `clear` in HOLDING with the button held. All outputs read 0 immediately. After `clear` falls, exactly one `pulse` after the 7th edge.

Source files
------------

// File: rtl/button_pulse_gen_pkg.sv
// Shared types and defaults for the pushbutton conditioning stage.
// Holds the FSM state enum, parameter defaults and a timer sizing helper.
package button_pulse_gen_pkg;

  typedef enum logic [2:0] {
    S_RELEASED    = 3'd0,
    S_PRESS_DEB   = 3'd1,
    S_PRESSED     = 3'd2,
    S_HOLDING     = 3'd3,
    S_RELEASE_DEB = 3'd4
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_HOLD_CYCLES     = 64;
  localparam int unsigned DEF_REPEAT_CYCLES   = 32;
  localparam int unsigned DEF_CNT_W           = 16;

  // Smallest timer width that can reach max(a,b,c)-1.
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_pulse_gen_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops clear asynchronously; reusable by other input stages.
module sync_2ff (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_pulse_gen.sv
// Debounces a raw pushbutton into a one-cycle press pulse,
// with optional hold-to-auto-repeat.
module button_pulse_gen
  import button_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clock,
  input  logic clear,
  input  logic button_in,
  input  logic repeat_en,
  output logic pulse,
  output logic button_level,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             w_btn_s;
  btn_state_t       r_state;
  btn_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             w_pulse_set;
  logic             w_cnt_rst;

  sync_2ff u_sync (
    .i_clk (clock),
    .i_clr (clear),
    .i_d   (button_in),
    .o_q   (w_btn_s)
  );

  // State, shared timer and registered pulse.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_RELEASED;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_rst ? '0 : r_cnt + CNT_W'(1);
      r_pulse <= w_pulse_set;
    end
  end

  // Next state; release always wins over repeat and timer expiry.
  always_comb begin
    w_next      = r_state;
    w_pulse_set = 1'b0;
    w_cnt_rst   = 1'b0;
    unique case (r_state)
      S_RELEASED: begin
        w_cnt_rst = 1'b1;
        if (w_btn_s) w_next = S_PRESS_DEB;
      end
      S_PRESS_DEB: begin
        if (!w_btn_s) begin
          w_next = S_RELEASED;
        end else if (r_cnt == DEB_LAST) begin
          w_next      = S_PRESSED;
          w_pulse_set = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!w_btn_s) begin
          w_next = S_RELEASE_DEB;
        end else if (!repeat_en) begin
          w_cnt_rst = 1'b1;
        end else if (r_cnt == HLD_LAST) begin
          w_next      = S_HOLDING;
          w_pulse_set = 1'b1;
        end
      end
      S_HOLDING: begin
        if (!w_btn_s) begin
          w_next = S_RELEASE_DEB;
        end else if (!repeat_en) begin
          w_next = S_PRESSED;
        end else if (r_cnt == REP_LAST) begin
          w_pulse_set = 1'b1;
          w_cnt_rst   = 1'b1;
        end
      end
      S_RELEASE_DEB: begin
        if (w_btn_s) begin
          w_next = S_PRESSED;
        end else if (r_cnt == DEB_LAST) begin
          w_next = S_RELEASED;
        end
      end
      default: w_next = S_RELEASED;
    endcase
    if (w_next != r_state) w_cnt_rst = 1'b1;
  end

  // Level outputs decoded from state only.
  always_comb begin
    button_level = 1'b0;
    held         = 1'b0;
    unique case (1'b1)
      (r_state == S_PRESSED),
      (r_state == S_RELEASE_DEB): button_level = 1'b1;
      (r_state == S_HOLDING): begin
        button_level = 1'b1;
        held         = 1'b1;
      end
      default: ;
    endcase
  end

  assign pulse = r_pulse;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench for button_pulse_gen: stimulus queues expected
// pulse edges, a negedge monitor pops and compares them.
module tb_button_pulse_gen;

  logic clock     = 1'b0;
  logic clear     = 1'b0;
  logic button_in = 1'b0;
  logic repeat_en = 1'b0;
  logic pulse;
  logic button_level;
  logic held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int base;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (8),
    .REPEAT_CYCLES   (4),
    .CNT_W           (16)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .button_in    (button_in),
    .repeat_en    (repeat_en),
    .pulse        (pulse),
    .button_level (button_level),
    .held         (held)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: every observed pulse must match the next queued edge.
  always @(negedge clock) begin
    int e;
    if (pulse !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual edge %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_edge", cyc, e);
      end
    end
  end

  initial begin
    #1 clear = 1'b1;
    #1;
    chk("rst_pulse", pulse, 0);
    chk("rst_level", button_level, 0);
    chk("rst_held", held, 0);
    step(2);
    clear = 1'b0;
    step(2);

    // Clean press, no repeat
    repeat_en = 1'b0;
    base = cyc;
    button_in = 1'b1;
    exp_q.push_back(base + 7);
    step(6);
    chk("clean_level_e6", button_level, 0);
    step(1);
    chk("clean_level_e7", button_level, 1);
    chk("clean_held_e7", held, 0);
    step(13);
    button_in = 1'b0;
    step(6);
    chk("clean_level_e26", button_level, 1);
    step(1);
    chk("clean_level_e27", button_level, 0);
    step(3);

    // Bounce 1,0,1,0,1,0 then steady 1 from edge 7
    base = cyc;
    exp_q.push_back(base + 13);
    for (int i = 0; i < 6; i++) begin
      button_in = (i % 2 == 0);
      step(1);
    end
    button_in = 1'b1;
    step(6);
    chk("bounce_level_e12", button_level, 0);
    step(1);
    chk("bounce_level_e13", button_level, 1);
    step(5);
    button_in = 1'b0;
    step(10);
    chk("bounce_released", button_level, 0);

    // Auto-repeat
    repeat_en = 1'b1;
    base = cyc;
    button_in = 1'b1;
    exp_q.push_back(base + 7);
    exp_q.push_back(base + 15);
    exp_q.push_back(base + 19);
    exp_q.push_back(base + 23);
    exp_q.push_back(base + 27);
    exp_q.push_back(base + 31);
    step(14);
    chk("rep_held_e14", held, 0);
    step(1);
    chk("rep_held_e15", held, 1);
    step(15);
    button_in = 1'b0;
    step(2);
    chk("rep_held_e32", held, 1);
    step(1);
    chk("rep_held_e33", held, 0);
    chk("rep_level_e33", button_level, 1);
    step(3);
    chk("rep_level_e36", button_level, 1);
    step(1);
    chk("rep_level_e37", button_level, 0);
    step(2);

    // Release glitch restarts hold timer, then repeat_en drop
    repeat_en = 1'b1;
    base = cyc;
    button_in = 1'b1;
    exp_q.push_back(base + 7);
    exp_q.push_back(base + 20);
    step(8);
    button_in = 1'b0;
    step(1);
    button_in = 1'b1;
    step(2);
    chk("glitch_level_e11", button_level, 1);
    step(1);
    chk("glitch_level_e12", button_level, 1);
    chk("glitch_held_e12", held, 0);
    step(7);
    chk("glitch_held_e19", held, 0);
    step(1);
    chk("glitch_held_e20", held, 1);
    step(2);
    chk("drop_held_e22", held, 1);
    repeat_en = 1'b0;
    step(1);
    chk("drop_held_e23", held, 0);
    chk("drop_level_e23", button_level, 1);
    step(12);
    chk("drop_still_pressed", button_level, 1);
    button_in = 1'b0;
    step(10);
    chk("drop_released", button_level, 0);

    // Clear while holding, button still pressed
    repeat_en = 1'b1;
    base = cyc;
    button_in = 1'b1;
    exp_q.push_back(base + 7);
    exp_q.push_back(base + 15);
    step(17);
    chk("pre_clr_held", held, 1);
    clear = 1'b1;
    #1;
    chk("clr_pulse", pulse, 0);
    chk("clr_level", button_level, 0);
    chk("clr_held", held, 0);
    step(2);
    clear = 1'b0;
    base = cyc;
    exp_q.push_back(base + 7);
    step(12);
    button_in = 1'b0;
    step(10);
    chk("post_clr_level", button_level, 0);
    chk("post_clr_held", held, 0);

    step(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
